// File: rtl/uart_interface_ctrl_pkg.sv
// rtl/uart_interface_ctrl_pkg.sv - shared types and constants for the UART bus interface controller

package uart_interface_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    localparam int CTRL_SEND    = 0;
    localparam int CTRL_NEW_RX  = 1;
    localparam int CTRL_OVERRUN = 2;

    localparam logic REG_SEL_CTRL = 1'b0;
    localparam logic REG_SEL_DATA = 1'b1;

    localparam logic ADDR_TX = 1'b0;
    localparam logic ADDR_RX = 1'b1;

    function automatic logic [31:0] pack_ctrl(input logic send, input logic new_rx, input logic overrun);
        logic [31:0] word;
        word               = '0;
        word[CTRL_SEND]    = send;
        word[CTRL_NEW_RX]  = new_rx;
        word[CTRL_OVERRUN] = overrun;
        return word;
    endfunction

endpackage

// File: rtl/uart_interface_ctrl.sv
// rtl/uart_interface_ctrl.sv - CPU register front end and transmit handshake FSM for a UART core

module uart_interface_ctrl
    import uart_interface_ctrl_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        reg_sel_i,
    input  logic        addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_busy_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    tx_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        send_q, send_d;
    logic        new_rx_q, new_rx_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rx_data_q, rx_data_d;

    logic        ctrl_wr;
    logic        tx_wr;
    logic        send_clr;
    logic        unused_data;

    assign ctrl_wr     = we_i && (reg_sel_i == REG_SEL_CTRL);
    assign tx_wr       = we_i && (reg_sel_i == REG_SEL_DATA) && (addr_i == ADDR_TX);
    assign unused_data = ^data_i[31:8];

    // Transmit handshake: one-cycle start, then wait for the core to go busy and idle again
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        send_clr   = 1'b0;
        tx_start_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (send_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start_o = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    send_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    send_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        send_d    = send_q;
        new_rx_d  = new_rx_q;
        ovr_d     = ovr_q;
        tx_data_d = tx_data_q;
        rx_data_d = rx_data_q;

        if (send_clr) begin
            send_d = 1'b0;
        end else if (ctrl_wr && data_i[CTRL_SEND] && !send_q) begin
            send_d = 1'b1;
        end

        if (tx_wr && !send_q) begin
            tx_data_d = data_i[7:0];
        end

        // Software clears are applied first so a same-cycle receive wins
        if (ctrl_wr && !data_i[CTRL_NEW_RX]) begin
            new_rx_d = 1'b0;
        end
        if (ctrl_wr && !data_i[CTRL_OVERRUN]) begin
            ovr_d = 1'b0;
        end
        if (rx_valid_i) begin
            rx_data_d = rx_data_i;
            new_rx_d  = 1'b1;
            if (new_rx_q) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            send_q    <= 1'b0;
            new_rx_q  <= 1'b0;
            ovr_q     <= 1'b0;
            tx_data_q <= 8'h00;
            rx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            send_q    <= send_d;
            new_rx_q  <= new_rx_d;
            ovr_q     <= ovr_d;
            tx_data_q <= tx_data_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign tx_data_o = tx_data_q;

    always_comb begin
        data_o = '0;
        if (reg_sel_i == REG_SEL_CTRL) begin
            data_o = pack_ctrl(send_q, new_rx_q, ovr_q);
        end else if (addr_i == ADDR_TX) begin
            data_o = {24'b0, tx_data_q};
        end else begin
            data_o = {24'b0, rx_data_q};
        end
    end

endmodule

// File: tb/tb_uart_interface_ctrl.sv
// tb/tb_uart_interface_ctrl.sv - directed self-checking bench for uart_interface_ctrl

module tb_uart_interface_ctrl;
    import uart_interface_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        we_i = 1'b0;
    logic        reg_sel_i = 1'b0;
    logic        addr_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_busy_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int dbl_start = 0;
    logic prev_start = 1'b0;

    uart_interface_ctrl #(.BUSY_TIMEOUT(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (we_i),
        .reg_sel_i  (reg_sel_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_busy_i  (tx_busy_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (tx_start_o) start_cnt++;
        if (tx_start_o && prev_start) dbl_start++;
        prev_start = tx_start_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write(input logic sel, input logic adr, input logic [31:0] val);
        we_i = 1'b1; reg_sel_i = sel; addr_i = adr; data_i = val;
        tick();
        we_i = 1'b0; data_i = '0;
    endtask

    task automatic read_check(input string tag, input logic sel, input logic adr, input logic [31:0] exp);
        reg_sel_i = sel; addr_i = adr;
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid_i = 1'b1; rx_data_i = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (tx_start_o) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        tick(); tick();
        rst_i = 1'b0;
        read_check("rst_ctrl", REG_SEL_CTRL, ADDR_TX, 32'h0);
        read_check("rst_tx", REG_SEL_DATA, ADDR_TX, 32'h0);
        read_check("rst_rx", REG_SEL_DATA, ADDR_RX, 32'h0);
        check("rst_txdata", {24'b0, tx_data_o}, 32'h0);
        check("rst_start", {31'b0, tx_start_o}, 32'h0);

        // Normal transmit with core busy for 10 cycles
        write(REG_SEL_DATA, ADDR_TX, 32'h0000_0041);
        write(REG_SEL_CTRL, ADDR_TX, 32'h1);
        wait_start("t1_start");
        tick(); tick();
        tx_busy_i = 1'b1;
        tick();
        write(REG_SEL_DATA, ADDR_TX, 32'h0000_0055);
        read_check("t1_tx_locked", REG_SEL_DATA, ADDR_TX, 32'h41);
        write(REG_SEL_CTRL, ADDR_TX, 32'h0);
        read_check("t1_send_held", REG_SEL_CTRL, ADDR_TX, 32'h1);
        for (int i = 0; i < 7; i++) tick();
        tx_busy_i = 1'b0;
        tick();
        read_check("t1_send_clr", REG_SEL_CTRL, ADDR_TX, 32'h0);
        check("t1_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
        check("t1_txdata", {24'b0, tx_data_o}, 32'h41);
        tick(); tick(); tick();
        check("t1_one_pulse", start_cnt, 32'd1);

        // Busy timeout: core never responds
        write(REG_SEL_CTRL, ADDR_TX, 32'h1);
        wait_start("t2_start");
        for (int i = 0; i < 16; i++) tick();
        read_check("t2_send_before", REG_SEL_CTRL, ADDR_TX, 32'h1);
        check("t2_state_before", {30'b0, dut.state_q}, {30'b0, ST_WAIT_BUSY});
        tick();
        read_check("t2_send_after", REG_SEL_CTRL, ADDR_TX, 32'h0);
        check("t2_state_after", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
        tick(); tick();
        check("t2_pulses", start_cnt, 32'd2);

        // Receive path, overrun and clears
        rx_byte(8'h5A);
        read_check("t3_ctrl1", REG_SEL_CTRL, ADDR_TX, 32'h2);
        read_check("t3_rx1", REG_SEL_DATA, ADDR_RX, 32'h5A);
        rx_byte(8'hA5);
        read_check("t3_rx2", REG_SEL_DATA, ADDR_RX, 32'hA5);
        read_check("t3_ctrl2", REG_SEL_CTRL, ADDR_TX, 32'h6);
        write(REG_SEL_DATA, ADDR_RX, 32'h0000_00FF);
        read_check("t3_rx_ro", REG_SEL_DATA, ADDR_RX, 32'hA5);
        write(REG_SEL_CTRL, ADDR_TX, 32'h6);
        read_check("t3_w1_ignored", REG_SEL_CTRL, ADDR_TX, 32'h6);
        write(REG_SEL_CTRL, ADDR_TX, 32'h0);
        read_check("t3_clr", REG_SEL_CTRL, ADDR_TX, 32'h0);

        // Receive in same cycle as software clear: set wins
        rx_valid_i = 1'b1; rx_data_i = 8'h3C;
        write(REG_SEL_CTRL, ADDR_TX, 32'h0);
        rx_valid_i = 1'b0;
        read_check("t4_set_wins", REG_SEL_CTRL, ADDR_TX, 32'h2);
        read_check("t4_rx", REG_SEL_DATA, ADDR_RX, 32'h3C);

        // Reset in the middle of a transmission
        write(REG_SEL_DATA, ADDR_TX, 32'h0000_0077);
        write(REG_SEL_CTRL, ADDR_TX, 32'h1);
        wait_start("t5_start");
        tx_busy_i = 1'b1;
        tick(); tick();
        check("t5_in_done", {30'b0, dut.state_q}, {30'b0, ST_WAIT_DONE});
        rst_i = 1'b1;
        tick();
        check("t5_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
        read_check("t5_ctrl", REG_SEL_CTRL, ADDR_TX, 32'h0);
        read_check("t5_tx", REG_SEL_DATA, ADDR_TX, 32'h0);
        read_check("t5_rx", REG_SEL_DATA, ADDR_RX, 32'h0);
        check("t5_txdata", {24'b0, tx_data_o}, 32'h0);
        rx_valid_i = 1'b1; rx_data_i = 8'h99;
        write(REG_SEL_CTRL, ADDR_TX, 32'h1);
        rx_valid_i = 1'b0;
        read_check("t5_rst_wr_ctrl", REG_SEL_CTRL, ADDR_TX, 32'h0);
        read_check("t5_rst_wr_rx", REG_SEL_DATA, ADDR_RX, 32'h0);
        rst_i = 1'b0;
        tx_busy_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_start", start_cnt, 32'd3);
        write(REG_SEL_CTRL, ADDR_TX, 32'h1);
        wait_start("t5_restart");
        tick();
        check("t5_pulses", start_cnt, 32'd4);
        check("no_back_to_back", dbl_start, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
